// File: rtl/wrom_burst_arbiter_if.sv
// Requester/ROM-side bundle of the weights-ROM burst arbiter.
// Define WROM_ARB_LOCK_EN to add the per-requester req_lock inputs.
interface wrom_burst_arbiter_if #(
  parameter int N    = 8,
  parameter int AW   = 8,
  parameter int NREQ = 2,
  parameter int LW   = 5
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ*AW-1:0] req_stride;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [AW-1:0]      rom_addr;
  logic [N-1:0]       rom_data;
  logic               rd_valid;
  logic [N-1:0]       rd_data;
  logic [1:0]         rd_id;
  logic               rd_last;
`ifdef WROM_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;

  modport master (
    output req, req_addr, req_len, req_stride, req_lock, rom_data,
    input  gnt, busy, rom_addr, rd_valid, rd_data, rd_id, rd_last
  );
  modport slave (
    input  req, req_addr, req_len, req_stride, req_lock, rom_data,
    output gnt, busy, rom_addr, rd_valid, rd_data, rd_id, rd_last
  );
`else
  modport master (
    output req, req_addr, req_len, req_stride, rom_data,
    input  gnt, busy, rom_addr, rd_valid, rd_data, rd_id, rd_last
  );
  modport slave (
    input  req, req_addr, req_len, req_stride, rom_data,
    output gnt, busy, rom_addr, rd_valid, rd_data, rd_id, rd_last
  );
`endif
endinterface

// File: rtl/wrom_burst_arbiter.sv
// Round-robin strided-burst arbiter in front of the shared 1-cycle-latency weights ROM.
// Optional macro WROM_ARB_LOCK_EN: a locked requester keeps the ROM for up to 8 bursts.
module wrom_burst_arbiter #(
  parameter int N    = 8,
  parameter int AW   = 8,
  parameter int NREQ = 2,
  parameter int LW   = 5
) (
  input logic clk,
  input logic rst,
  wrom_burst_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d, stride_q, stride_d, rom_addr_q, rom_addr_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [1:0]      id_q, id_d, rr_ptr_q, rr_ptr_d;
  logic [1:0]      iss_id_q, iss_id_d, rd_id_q, rd_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            iss_q, iss_d, iss_last_q, iss_last_d;
  logic            rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;

  logic            rr_found;
  logic [1:0]      rr_pick;
  logic            grant;
  logic [1:0]      gid;
  logic [NREQ-1:0] gnt_sel;
  logic [AW-1:0]   addr_v [NREQ];
  logic [AW-1:0]   stride_v [NREQ];
  logic [LW-1:0]   len_v [NREQ];
  logic [AW-1:0]   sel_addr, sel_stride;
  logic [LW-1:0]   sel_len;

  // First asserted request scanning upward from the requester after rr_ptr.
  always_comb begin
    logic [NREQ-1:0] rot;
    rot      = '0;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rot = bus.req >> ((int'(rr_ptr_q) + k) % NREQ);
      if (!rr_found && rot[0]) begin
        rr_found = 1'b1;
        rr_pick  = 2'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

`ifdef WROM_ARB_LOCK_EN
  logic            lock_pend_q, lock_pend_d;
  logic [3:0]      run_q, run_d;
  logic [NREQ-1:0] own_req_v, own_lock_v;
  logic            lock_grant;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_own
    assign own_req_v[gi]  = (id_q == 2'(gi)) && bus.req[gi];
    assign own_lock_v[gi] = (id_q == 2'(gi)) && bus.req[gi] && bus.req_lock[gi];
  end

  assign lock_grant = lock_pend_q && (|own_req_v);
  assign grant      = lock_grant || rr_found;
  assign gid        = lock_grant ? id_q : rr_pick;
`else
  assign grant = rr_found;
  assign gid   = rr_pick;
`endif

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fields
    assign gnt_sel[gi]  = (gid == 2'(gi));
    assign addr_v[gi]   = gnt_sel[gi] ? bus.req_addr[gi*AW +: AW]   : '0;
    assign stride_v[gi] = gnt_sel[gi] ? bus.req_stride[gi*AW +: AW] : '0;
    assign len_v[gi]    = gnt_sel[gi] ? bus.req_len[gi*LW +: LW]    : '0;
  end

  always_comb begin
    sel_addr   = '0;
    sel_stride = '0;
    sel_len    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_addr   = sel_addr | addr_v[k];
      sel_stride = sel_stride | stride_v[k];
      sel_len    = sel_len | len_v[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    stride_d   = stride_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    gnt_d      = '0;
    iss_d      = 1'b0;
    iss_last_d = 1'b0;
    iss_id_d   = id_q;
    // Read-return stage lines up with rom_data, one cycle behind the issued address.
    rd_valid_d = iss_q;
    rd_last_d  = iss_q && iss_last_q;
    rd_id_d    = iss_id_q;
`ifdef WROM_ARB_LOCK_EN
    lock_pend_d = lock_pend_q;
    run_d       = run_q;
`endif
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
`ifdef WROM_ARB_LOCK_EN
        lock_pend_d = 1'b0;
`endif
        if (grant) begin
          gnt_d      = gnt_sel;
          id_d       = gid;
          rr_ptr_d   = gid;
          cur_addr_d = sel_addr;
          stride_d   = sel_stride;
          cnt_d      = sel_len;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = BURST;
`ifdef WROM_ARB_LOCK_EN
          run_d = lock_grant ? run_q + 4'd1 : 4'd1;
`endif
        end
      end
      BURST: begin
        busy_d = 1'b1;
        // One extra BURST cycle after the last address lets the last word reach DRAIN.
        if (done_q) begin
          state_d = DRAIN;
        end else begin
          rom_addr_d = cur_addr_q;
          cur_addr_d = cur_addr_q + stride_q;
          iss_d      = 1'b1;
          iss_last_d = (cnt_q == '0);
          if (cnt_q == '0) done_d = 1'b1;
          else             cnt_d  = cnt_q - LW'(1);
        end
      end
      DRAIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef WROM_ARB_LOCK_EN
        lock_pend_d = (|own_lock_v) && (run_q < 4'd8);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      stride_q   <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      rr_ptr_q   <= 2'(NREQ - 1);
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gnt_q      <= '0;
      iss_q      <= 1'b0;
      iss_last_q <= 1'b0;
      iss_id_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_id_q    <= '0;
`ifdef WROM_ARB_LOCK_EN
      lock_pend_q <= 1'b0;
      run_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      stride_q   <= stride_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gnt_q      <= gnt_d;
      iss_q      <= iss_d;
      iss_last_q <= iss_last_d;
      iss_id_q   <= iss_id_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_id_q    <= rd_id_d;
`ifdef WROM_ARB_LOCK_EN
      lock_pend_q <= lock_pend_d;
      run_q       <= run_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_id    = rd_id_q;
  assign bus.rd_data  = bus.rom_data;
endmodule

// File: tb/tb_wrom_burst_arbiter.sv
// Bench for wrom_burst_arbiter: directed bursts, contention, reset abort and random traffic
// checked against a burst-level reference model and a registered ROM model.
module tb_wrom_burst_arbiter;
  localparam int N    = 8;
  localparam int AW   = 8;
  localparam int NREQ = 2;
  localparam int LW   = 5;
  localparam int IW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wrom_burst_arbiter_if #(.N(N), .AW(AW), .NREQ(NREQ), .LW(LW)) bus ();
  wrom_burst_arbiter #(.N(N), .AW(AW), .NREQ(NREQ), .LW(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [N-1:0] mem [256];
  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  int errors = 0;
  int checks = 0;

  logic [AW-1:0]   f_addr   [NREQ];
  logic [LW-1:0]   f_len    [NREQ];
  logic [AW-1:0]   f_stride [NREQ];
  logic [NREQ-1:0] lock_m;
  int rr_last, last_id, run;
  bit lock_pend_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [AW-1:0] addr_k(input logic [AW-1:0] a, input logic [AW-1:0] s, input int k);
    return AW'((int'(a) + k * int'(s)) % (1 << AW));
  endfunction

  task automatic put_fields();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW]   = f_addr[IW'(i)];
      bus.req_len[i*LW +: LW]    = f_len[IW'(i)];
      bus.req_stride[i*AW +: AW] = f_stride[IW'(i)];
    end
`ifdef WROM_ARB_LOCK_EN
    bus.req_lock = lock_m;
`endif
  endtask

  task automatic set_fields(input int i, input int a, input int l, input int s);
    f_addr[IW'(i)]   = AW'(a);
    f_len[IW'(i)]    = LW'(l);
    f_stride[IW'(i)] = AW'(s);
    put_fields();
  endtask

  task automatic rand_fields(input int i, input int maxlen);
    set_fields(i, int'($urandom_range(0, 255)), int'($urandom_range(0, maxlen)),
               int'($urandom_range(0, 255)));
  endtask

  task automatic model_reset();
    rr_last     = NREQ - 1;
    last_id     = -1;
    run         = 0;
    lock_pend_m = 1'b0;
  endtask

  // Who the arbiter should grant, given the requests visible in this IDLE cycle.
  function automatic int exp_winner(output bit forced);
    forced = 1'b0;
    if (lock_pend_m && last_id >= 0 && bit_of(bus.req, last_id)) begin
      forced = 1'b1;
      return last_id;
    end
    for (int k = 1; k <= NREQ; k++) begin
      if (bit_of(bus.req, (rr_last + k) % NREQ)) return (rr_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_burst(input bit hold, output int wid);
    int ew;
    int l;
    bit forced;
    bit seen;
    logic [AW-1:0] a0, s;
    seen = 1'b0;
    wid  = -1;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(negedge clk);
      seen = (bus.gnt != '0);
    end
    chk("gnt_seen", 32'(seen), 32'd1);
    if (!seen) return;
    ew = exp_winner(forced);
    lock_pend_m = 1'b0;
    chk("gnt_onehot", 32'(bus.gnt), (ew < 0) ? 32'd0 : (32'd1 << ew));
    chk("busy_at_gnt", 32'(bus.busy), 32'd1);
    for (int i = 0; i < NREQ; i++) if (bit_of(bus.gnt, i)) wid = i;
    if (ew < 0) return;
    a0 = f_addr[IW'(ew)];
    l  = int'(f_len[IW'(ew)]);
    s  = f_stride[IW'(ew)];
    run     = forced ? run + 1 : 1;
    rr_last = ew;
    last_id = ew;
    if (hold) rand_fields(ew, 7);
    else      bus.req[IW'(ew)] = 1'b0;
    for (int j = 0; j <= l + 1; j++) begin
      @(negedge clk);
      if (j <= l) chk("rom_addr", 32'(bus.rom_addr), 32'(addr_k(a0, s, j)));
      chk("gnt_quiet", 32'(bus.gnt), 32'd0);
      chk("busy", 32'(bus.busy), 32'd1);
      chk("rd_valid", 32'(bus.rd_valid), 32'(j >= 1));
      chk("rd_last", 32'(bus.rd_last), 32'(j == l + 1));
      if (j >= 1) begin
        chk("rd_data", 32'(bus.rd_data), 32'(mem[addr_k(a0, s, j - 1)]));
        chk("rd_id", 32'(bus.rd_id), 32'(ew));
      end
`ifdef WROM_ARB_LOCK_EN
      if (j == l + 1) lock_pend_m = lock_m[IW'(ew)] && bit_of(bus.req, ew) && (run < 8);
`endif
    end
    @(negedge clk);
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("rd_valid_end", 32'(bus.rd_valid), 32'd0);
    chk("rom_addr_hold", 32'(bus.rom_addr), 32'(addr_k(a0, s, l)));
  endtask

  initial begin
    int w, prev, cur, maxrun;
    bit seen;
    logic [AW-1:0] ra, rs;
    foreach (mem[i]) mem[i] = N'($urandom);
    bus.req = '0;
    lock_m  = '0;
    for (int i = 0; i < NREQ; i++) set_fields(i, 0, 0, 0);
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_last", 32'(bus.rd_last), 32'd0);
    chk("rst_rd_id", 32'(bus.rd_id), 32'd0);
    rst = 1'b0;

    set_fields(0, 0, 4, 1);
    bus.req = NREQ'(1);
    do_burst(1'b0, w);
    chk("single_id", 32'(w), 32'd0);

    set_fields(1, 250, 2, 16);
    bus.req[1] = 1'b1;
    do_burst(1'b0, w);
    chk("wrap_id", 32'(w), 32'd1);

    set_fields(0, int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 255)));
    bus.req[0] = 1'b1;
    do_burst(1'b0, w);
    set_fields(1, int'($urandom_range(0, 255)), 31, 1);
    bus.req[1] = 1'b1;
    do_burst(1'b0, w);
    set_fields(0, int'($urandom_range(0, 255)), 5, 0);
    bus.req[0] = 1'b1;
    do_burst(1'b0, w);

    rand_fields(0, 7);
    rand_fields(1, 7);
    bus.req = '1;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      do_burst(1'b1, w);
      if (k > 0) chk("rr_alternate", 32'(w != prev), 32'd1);
      prev = w;
    end
    bus.req = '0;

    ra = AW'($urandom);
    rs = AW'($urandom);
    set_fields(0, int'(ra), 7, int'(rs));
    bus.req[0] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(negedge clk);
      seen = (bus.gnt != '0);
    end
    chk("rstmid_gnt_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("rstmid_addr", 32'(bus.rom_addr), 32'(addr_k(ra, rs, 2)));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b0;
    model_reset();
    rand_fields(0, 7);
    rand_fields(1, 7);
    bus.req = '1;
    do_burst(1'b0, w);
    chk("rstmid_first", 32'(w), 32'd0);
    do_burst(1'b0, w);
    chk("rstmid_second", 32'(w), 32'd1);

`ifdef WROM_ARB_LOCK_EN
    lock_m = NREQ'(2);
    rand_fields(0, 3);
    rand_fields(1, 3);
    bus.req = '1;
    cur = 0;
    maxrun = 0;
    for (int k = 0; k < 12; k++) begin
      do_burst(1'b1, w);
      cur = (w == 1) ? cur + 1 : 0;
      if (cur > maxrun) maxrun = cur;
    end
    chk("lock_run", 32'(maxrun), 32'd8);
    bus.req = '0;
    lock_m  = '0;
    put_fields();
`else
    cur = 0;
    maxrun = 0;
`endif

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bit_of(bus.req, i) && $urandom_range(0, 1) == 1) begin
          rand_fields(i, 7);
          bus.req[IW'(i)] = 1'b1;
        end
      end
      if (bus.req == '0) begin
        rand_fields(0, 7);
        bus.req[0] = 1'b1;
      end
      do_burst(1'($urandom_range(0, 1)), w);
    end
    bus.req = '0;
    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_gnt", 32'(bus.gnt), 32'd0);
    chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
